// File: rtl/microstep_sequencer.sv
// Execute-phase microstep sequencer: walks {opcode, step} through the microcode store and flags HALT/overrun/protocol errors.
// Latency: first EXEC cycle is the cycle after exec_start_i; control_o and exec_done_o follow ucode_word_i combinationally.
// Backpressure: none; exec_start_i is a fire-and-forget pulse, and a pulse arriving while busy is dropped and flagged.
module microstep_sequencer #(
    parameter int OPCODE_WIDTH = 8,
    parameter int MS_WIDTH     = 3,
    parameter int CTRL_WIDTH   = 24
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             exec_start_i,
    input  logic [OPCODE_WIDTH-1:0]          opcode_i,
    output logic [OPCODE_WIDTH+MS_WIDTH-1:0] ucode_addr_o,
    input  logic [CTRL_WIDTH-1:0]            ucode_word_i,
    output logic [CTRL_WIDTH-3:0]            control_o,
    output logic [MS_WIDTH-1:0]              current_microstep,
    output logic                             exec_busy_o,
    output logic                             exec_done_o,
    output logic                             halted_o,
    output logic                             ucode_overrun_o,
    output logic                             protocol_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [MS_WIDTH-1:0]     step_q, step_d;
    logic                    halted_q, halted_d;
    logic                    ovr_q, ovr_d;
    logic                    perr_q, perr_d;

    logic word_last;
    logic word_halt;
    logic step_max;

    assign word_last = ucode_word_i[CTRL_WIDTH-1];
    assign word_halt = ucode_word_i[CTRL_WIDTH-2];
    // The counter must never wrap: the all-ones step is treated as an implicit LAST.
    assign step_max  = &step_q;

    assign ucode_addr_o      = {opcode_q, step_q};
    assign current_microstep = step_q;
    assign halted_o          = halted_q;
    assign ucode_overrun_o   = ovr_q;
    assign protocol_err_o    = perr_q;

    // Next-state, step sequencing and per-cycle outputs; outputs decode from state so reset clears them at once.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        step_d      = step_q;
        halted_d    = halted_q;
        ovr_d       = ovr_q;
        perr_d      = perr_q;
        control_o   = '0;
        exec_busy_o = 1'b0;
        exec_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (exec_start_i) begin
                    opcode_d = opcode_i;
                    step_d   = '0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                exec_busy_o = 1'b1;
                control_o   = ucode_word_i[CTRL_WIDTH-3:0];
                // Fetch must wait for done; a restart here (even on the final step) is dropped.
                if (exec_start_i) begin
                    perr_d = 1'b1;
                end
                if (word_halt) begin
                    halted_d = 1'b1;
                    state_d  = HALTED;
                end else if (word_last) begin
                    exec_done_o = 1'b1;
                    step_d      = '0;
                    state_d     = IDLE;
                end else if (step_max) begin
                    exec_done_o = 1'b1;
                    ovr_d       = 1'b1;
                    step_d      = '0;
                    state_d     = IDLE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            HALTED: begin
                // Only reset leaves HALTED; starts are silently ignored.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and sticky flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            step_q   <= '0;
            halted_q <= 1'b0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            step_q   <= step_d;
            halted_q <= halted_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
        end
    end

endmodule

// File: tb/tb_microstep_sequencer.sv
// Testbench for microstep_sequencer: directed vector table, hand-written corner sequences, random run against a trace model.
// Latency: outputs sampled 1 time unit after the falling edge, inputs driven at the falling edge.
// Backpressure: not applicable; the bench supplies the microcode store combinationally.
module tb_microstep_sequencer;

    localparam int OW = 8;
    localparam int MW = 3;
    localparam int CW = 24;

    logic           clk;
    logic           reset;
    logic           exec_start;
    logic [OW-1:0]  opcode;
    logic [OW+MW-1:0] ucode_addr;
    logic [CW-1:0]  ucode_word;
    logic [CW-3:0]  control;
    logic [MW-1:0]  cur_step;
    logic           busy, done, halted, overrun, perr;

    logic [CW-1:0] ucode_mem [0:2047];

    int n_chk  = 0;
    int n_fail = 0;

    microstep_sequencer #(.OPCODE_WIDTH(OW), .MS_WIDTH(MW), .CTRL_WIDTH(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .exec_start_i     (exec_start),
        .opcode_i         (opcode),
        .ucode_addr_o     (ucode_addr),
        .ucode_word_i     (ucode_word),
        .control_o        (control),
        .current_microstep(cur_step),
        .exec_busy_o      (busy),
        .exec_done_o      (done),
        .halted_o         (halted),
        .ucode_overrun_o  (overrun),
        .protocol_err_o   (perr)
    );

    assign ucode_word = ucode_mem[ucode_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int addr, input int step, input int bsy, input int dn,
                           input int ctrl, input int hlt, input int ovr, input int pe);
        chk({tag, ".addr"},    32'(ucode_addr), 32'(addr));
        chk({tag, ".step"},    32'(cur_step),   32'(step));
        chk({tag, ".busy"},    32'(busy),       32'(bsy));
        chk({tag, ".done"},    32'(done),       32'(dn));
        chk({tag, ".ctrl"},    32'(control),    32'(ctrl));
        chk({tag, ".halted"},  32'(halted),     32'(hlt));
        chk({tag, ".overrun"}, 32'(overrun),    32'(ovr));
        chk({tag, ".perr"},    32'(perr),       32'(pe));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int rst, start, op;
        int addr, step, bsy, dn, ctrl, hlt, ovr, pe;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input int rst, input int start, input int op, input int addr, input int step,
                                input int bsy, input int dn, input int ctrl, input int hlt, input int ovr,
                                input int pe);
        vec_t v;
        v.rst = rst; v.start = start; v.op = op; v.addr = addr; v.step = step;
        v.bsy = bsy; v.dn = dn; v.ctrl = ctrl; v.hlt = hlt; v.ovr = ovr; v.pe = pe;
        return v;
    endfunction

    // ---------------- trace reference model ----------------
    typedef struct {
        int step;
        int ctrl;
        bit dn;
        bit halt_after;
        bit ovr_after;
    } cyc_t;

    cyc_t trace[$];
    int   m_op, m_hold;
    bit   m_halted, m_ovr, m_perr;

    task automatic model_reset();
        trace.delete();
        m_op = 0; m_hold = 0; m_halted = 0; m_ovr = 0; m_perr = 0;
    endtask

    // Expand an instruction into its full per-cycle trace by reading the microcode store.
    task automatic model_build(input int op);
        cyc_t c;
        logic [CW-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w = ucode_mem[op * 8 + k];
            c.step = k; c.ctrl = int'(w[CW-3:0]);
            c.dn = 0; c.halt_after = 0; c.ovr_after = 0;
            if (w[CW-2]) begin
                c.halt_after = 1; trace.push_back(c); break;
            end else if (w[CW-1]) begin
                c.dn = 1; trace.push_back(c); break;
            end else if (k == 7) begin
                c.dn = 1; c.ovr_after = 1; trace.push_back(c);
            end else begin
                trace.push_back(c);
            end
        end
    endtask

    task automatic model_step(input bit start, input int op);
        cyc_t c;
        if (trace.size() > 0) begin
            c = trace.pop_front();
            if (c.halt_after) begin
                m_halted = 1; m_hold = c.step;
            end
            if (c.ovr_after) m_ovr = 1;
            if (start) m_perr = 1;
        end else if (start && !m_halted) begin
            m_op = op;
            model_build(op);
        end
    endtask

    task automatic model_check(input string tag);
        if (trace.size() > 0)
            chk_all(tag, m_op * 8 + trace[0].step, trace[0].step, 1, int'(trace[0].dn), trace[0].ctrl,
                    int'(m_halted), int'(m_ovr), int'(m_perr));
        else
            chk_all(tag, m_op * 8 + (m_halted ? m_hold : 0), m_halted ? m_hold : 0, 0, 0, 0,
                    int'(m_halted), int'(m_ovr), int'(m_perr));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0; exec_start = 1'b0;
        #2 reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ucode_mem[i] = '0;
        // LDI_A: single step, LAST + oe_temp_1/load_a/load_status/load_sets_zn
        ucode_mem['h10 * 8 + 0] = 24'h80000F;
        // 3-step opcode, LAST at MS2
        ucode_mem['h20 * 8 + 0] = 24'h000011;
        ucode_mem['h20 * 8 + 1] = 24'h000022;
        ucode_mem['h20 * 8 + 2] = 24'h800044;
        // HLT
        ucode_mem['hFF * 8 + 0] = 24'h400100;
        // No LAST anywhere
        for (int k = 0; k < 8; k++) ucode_mem['h30 * 8 + k] = 24'(k + 1);

        tbl[0]  = mk(1, 1, 'h10, 0,           0, 0, 0, 0,     0, 0, 0);
        tbl[1]  = mk(1, 0, 0,    'h10 * 8,    0, 1, 1, 'hF,   0, 0, 0);
        tbl[2]  = mk(1, 0, 0,    'h10 * 8,    0, 0, 0, 0,     0, 0, 0);
        tbl[3]  = mk(1, 1, 'h20, 'h10 * 8,    0, 0, 0, 0,     0, 0, 0);
        tbl[4]  = mk(1, 0, 0,    'h20 * 8,    0, 1, 0, 'h11,  0, 0, 0);
        tbl[5]  = mk(1, 1, 'h10, 'h20 * 8 + 1, 1, 1, 0, 'h22, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0,    'h20 * 8 + 2, 2, 1, 1, 'h44, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0,    'h20 * 8,    0, 0, 0, 0,     0, 0, 1);
        tbl[8]  = mk(0, 0, 0,    0,           0, 0, 0, 0,     0, 0, 0);
        tbl[9]  = mk(1, 1, 'hFF, 0,           0, 0, 0, 0,     0, 0, 0);
        tbl[10] = mk(1, 0, 0,    'hFF * 8,    0, 1, 0, 'h100, 0, 0, 0);
        tbl[11] = mk(1, 1, 'h10, 'hFF * 8,    0, 0, 0, 0,     1, 0, 0);
        tbl[12] = mk(1, 0, 0,    'hFF * 8,    0, 0, 0, 0,     1, 0, 0);

        // Reset state, checked while reset is still asserted.
        reset = 1'b0; exec_start = 1'b0; opcode = '0;
        #2 chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            reset      = tbl[i].rst[0];
            exec_start = tbl[i].start[0];
            opcode     = tbl[i].op[OW-1:0];
            #1 chk_all($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].step, tbl[i].bsy, tbl[i].dn,
                       tbl[i].ctrl, tbl[i].hlt, tbl[i].ovr, tbl[i].pe);
        end

        // Overrun: no LAST bit, 8 EXEC cycles then back to IDLE with overrun flagged.
        pulse_reset();
        @(negedge clk);
        exec_start = 1'b1; opcode = 8'h30;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exec_start = 1'b0;
            #1 chk_all($sformatf("ovr_ms%0d", k), 'h30 * 8 + k, k, 1, (k == 7) ? 1 : 0, k + 1, 0, 0, 0);
        end
        @(negedge clk);
        #1 chk_all("ovr_after", 'h30 * 8, 0, 0, 0, 0, 0, 1, 0);

        // Reset asserted during MS1: outputs clear in the same timestep, then a fresh start runs from MS0.
        pulse_reset();
        @(negedge clk);
        exec_start = 1'b1; opcode = 8'h20;
        @(negedge clk);
        exec_start = 1'b0;
        @(negedge clk);
        #1 chk("mid_rst.pre_step", 32'(cur_step), 32'd1);
        reset = 1'b0;
        #1 chk_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exec_start = 1'b1; opcode = 8'h20;
        @(negedge clk);
        exec_start = 1'b0;
        #1 chk_all("mid_rst.restart", 'h20 * 8, 0, 1, 0, 'h11, 0, 0, 0);

        // Random microcode for opcodes 0x40..0x47; 0x47 never has LAST so overruns occur.
        for (int o = 'h40; o < 'h48; o++) begin
            for (int k = 0; k < 8; k++) begin
                logic last, hlt;
                logic [CW-3:0] c;
                last = ($urandom % 3 == 0) && (o != 'h47);
                hlt  = ($urandom % 24 == 0) && (o != 'h47);
                c    = (CW-2)'($urandom);
                ucode_mem[o * 8 + k] = {last, hlt, c};
            end
        end

        pulse_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit st;
            int op;
            @(negedge clk);
            if ((m_halted && ($urandom % 4 == 0)) || ($urandom % 150 == 0)) begin
                reset = 1'b0; exec_start = 1'b0;
                model_reset();
                #1 model_check($sformatf("rnd_rst%0d", cyc));
                #1 reset = 1'b1;
            end else begin
                #1 model_check($sformatf("rnd%0d", cyc));
                st = ($urandom % 3 == 0);
                op = 'h40 + int'($urandom % 8);
                exec_start = st;
                opcode     = op[OW-1:0];
                model_step(st, op);
            end
        end

        @(negedge clk);
        exec_start = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/microstep_sequencer.md
Name: microstep_sequencer

Overview:
- Execute-phase sequencer directly downstream of the CPU multi-byte fetch FSM.
- Fetch FSM pulses exec_start_i once opcode and operands are latched (after CHK_MORE_BYTES). This block steps MS0..MSn through the microcode store, drives the control word each cycle, and returns exec_done_o so fetch resumes at LATCH_ADDRESS the next cycle.
- Also owns HALT and microcode-overrun detection.

Parameters:
- OPCODE_WIDTH, 8, opcode width (matches arch_defs_pkg).
- MS_WIDTH, 3, microstep counter width; max steps = 2**MS_WIDTH (MS0..MS7).
- CTRL_WIDTH, 24, microcode word width. Bit [CTRL_WIDTH-1] = LAST, bit [CTRL_WIDTH-2] = HALT, bits [CTRL_WIDTH-3:0] = control signals.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- exec_start_i  in  1  one-cycle pulse from fetch FSM; opcode_i valid in the same cycle.
- opcode_i  in  OPCODE_WIDTH  opcode from IR.
- ucode_addr_o  out  OPCODE_WIDTH+MS_WIDTH  microcode address {opcode_q, current_microstep}.
- ucode_word_i  in  CTRL_WIDTH  microcode word; combinational, valid in the same cycle as ucode_addr_o.
- control_o  out  CTRL_WIDTH-2  control signals (oe_temp_1, load_a, load_status, load_sets_zn, ...).
- current_microstep  out  MS_WIDTH  active microstep (MS0 = 0).
- exec_busy_o  out  1  high while in EXEC.
- exec_done_o  out  1  high in the final microstep cycle.
- halted_o  out  1  sticky halt indication.
- ucode_overrun_o  out  1  sticky: last microstep reached without the LAST bit.
- protocol_err_o  out  1  sticky: exec_start_i arrived while not IDLE.

Behaviour:
- States: IDLE, EXEC, HALTED. Reset (reset=0, asynchronous) forces:
  - state=IDLE, opcode_q=0, current_microstep=0;
  - halted_o, ucode_overrun_o, protocol_err_o = 0.
- Deassertion of reset is synchronised externally; this block samples only on clk.
- IDLE:
  - control_o=0, exec_busy_o=0, exec_done_o=0; ucode_addr_o={opcode_q,0}.
  - On exec_start_i: latch opcode_q<=opcode_i, step<=MS0, go EXEC.
  - First EXEC cycle is the cycle after the start pulse (latency 1).
- EXEC:
  - exec_busy_o=1; control_o=ucode_word_i[CTRL_WIDTH-3:0] (combinational pass-through).
  - LAST=1, HALT=0: exec_done_o=1 this cycle; next state IDLE, step<=0.
  - HALT=1 (LAST ignored): control_o driven for this cycle, exec_done_o=0; next state HALTED, halted_o<=1.
  - LAST=0, step<max: step<=step+1.
  - LAST=0, step==max (all ones): treated as LAST. exec_done_o=1, ucode_overrun_o<=1, next IDLE. The step counter never wraps.
- HALTED:
  - control_o=0, exec_busy_o=0, exec_done_o=0, halted_o=1.
  - exec_start_i is ignored and does not set protocol_err_o.
  - Leaves only via reset.
- exec_start_i in EXEC: ignored (opcode_q and step unchanged); protocol_err_o<=1.
- exec_start_i in the same cycle as the LAST step: still an error. Fetch must not restart before done.
- Reset mid-EXEC: outputs return to reset values immediately (asynchronous). No exec_done_o is issued.
- Single-step instruction (LAST at MS0): exactly 1 EXEC cycle. exec_done_o and control_o are high in the same cycle.

Test Plan:
- LDI_A (opcode LDI_A), microcode MS0 = {LAST, oe_temp_1, load_a, load_status, load_sets_zn}. Pulse start -> next cycle: current_microstep=MS0, those 4 controls =1, exec_done_o=1; following cycle exec_busy_o=0, control_o=0.
- 3-step opcode with LAST at MS2 -> current_microstep 0,1,2 on consecutive cycles; exec_done_o only at MS2; ucode_addr_o = {op,0},{op,1},{op,2}.
- HLT opcode (HALT bit at MS0) -> halted_o=1 next cycle and stays. A later exec_start_i pulse leaves the state HALTED, with protocol_err_o=0 and exec_done_o=0.
- Microcode with no LAST bit -> 8 EXEC cycles (MS0..MS7); at MS7 exec_done_o=1; ucode_overrun_o=1 from the next cycle; state returns to IDLE.
- exec_start_i pulsed during MS1 of a 3-step opcode -> sequence completes unchanged with the original opcode_q; protocol_err_o=1 sticky.
- Assert reset=0 during MS1 -> same timestep: control_o=0, current_microstep=0, exec_busy_o=0. After release, a fresh start executes from MS0.
